// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner: synchroniser, debounce, press/release pulses.
// Define BUTTON_DEBOUNCE_LONGPRESS_EN to build the hold counters and btn_long.
module button_debounce #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 120000,
  parameter int LONG_CYCLES = 12000000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] btn_raw,
  output logic [N-1:0] btn_level,
  output logic [N-1:0] btn_press,
  output logic [N-1:0] btn_release,
  output logic [N-1:0] btn_long
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
    $error("button_debounce: SYNC_STAGES must be >= 2, DB_CYCLES and LONG_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0]                  sync;
  logic [N-1:0][DBW-1:0]         db_cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // A level is accepted only after DB_CYCLES consecutive samples disagree with it;
  // any agreeing sample restarts the count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      db_cnt      <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        btn_press[i]   <= 1'b0;
        btn_release[i] <= 1'b0;
        if (sync[i] == btn_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i]      <= '0;
          btn_level[i]   <= sync[i];
          btn_press[i]   <= sync[i];
          btn_release[i] <= ~sync[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_LONGPRESS_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

  logic [N-1:0][LW-1:0] hold_cnt;

  // The counter reads 0 during the press cycle, so btn_long lands LONG_CYCLES
  // cycles later; saturation keeps it to one pulse per press.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt <= '0;
      btn_long <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        btn_long[i] <= btn_level[i] && (hold_cnt[i] == LONG_LAST);
        if (!btn_level[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + LW'(1);
        end
      end
    end
  end
`else
  assign btn_long = '0;
`endif

endmodule

// File: doc/button_debounce.md
# button_debounce

Multi-channel push-button conditioner that sits directly upstream of the stopwatch control logic. It takes raw, asynchronous, bouncing button inputs from the dedicated input pins and synchronises and debounces each channel. Per channel it produces a clean level, one-cycle press and release pulses, and an optional long-press pulse. Its outputs drive the reset/start/stop/lap controls in place of raw pin levels.

## Interface
- `N`, 4: number of button channels.
- `SYNC_STAGES`, 2: synchroniser flops per channel, must be >= 2.
- `DB_CYCLES`, 120000: consecutive stable cycles required to accept a new level (10 ms at 12 MHz), must be >= 1.
- `LONG_CYCLES`, 12000000: held cycles after a press before `btn_long` fires (1 s at 12 MHz), must be >= 1.
- `CLK` in 1: single clock; all logic on its rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `btn_raw` in N: raw button pins, asynchronous, active-high, may bounce.
- `btn_level` out N: debounced level per channel.
- `btn_press` out N: one-cycle pulse on each debounced 0->1 transition.
- `btn_release` out N: one-cycle pulse on each debounced 1->0 transition.
- `btn_long` out N: one-cycle pulse when a press has been held `LONG_CYCLES` cycles.

## Operation
- Channels are fully independent and identical. Any combination may change in the same cycle.
- Synchroniser:
  - `SYNC_STAGES`-deep shift chain per channel; the last stage is `sync[i]`.
  - All stages reset to 0.
- Debounce counter per channel, width `$clog2(DB_CYCLES+1)`:
  - If `sync[i] == btn_level[i]`, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter would reach `DB_CYCLES`, `btn_level[i]` takes `sync[i]` and the counter clears.
  - Any glitch shorter than `DB_CYCLES` cycles is discarded and the count restarts.
- Pulses:
  - `btn_press[i]` / `btn_release[i]` are registered.
  - They are high exactly in the first cycle `btn_level[i]` shows the new value, and low otherwise.
- Hold counter per channel, width `$clog2(LONG_CYCLES+1)`:
  - Clears while `btn_level[i]` = 0 and in the cycle of `btn_press[i]`.
  - Otherwise increments while `btn_level[i]` = 1, saturating at `LONG_CYCLES`.
  - `btn_long[i]` pulses for one cycle when the counter steps from `LONG_CYCLES-1` to `LONG_CYCLES`.
  - Fires at most once per press. Releasing before that produces no `btn_long`.
- Per-channel state is LOW/HIGH, stored as `btn_level[i]`:
  - LOW -> HIGH after `DB_CYCLES` stable-high synchronised samples.
  - HIGH -> LOW after `DB_CYCLES` stable-low synchronised samples.
- Reset:
  - Synchronous `RST` clears all synchroniser, counter and output flops to 0.
  - Reset mid-count or mid-hold aborts without any pulse.
  - A button still held when `RST` deasserts is re-debounced from LOW and produces a fresh `btn_press`.

## Timing
- Reset value of every output: `btn_level`, `btn_press`, `btn_release`, `btn_long` = 0.
- Latency from the first rising edge sampling a new, stable `btn_raw` value to `btn_level`/pulse change: `SYNC_STAGES + DB_CYCLES` cycles.
- `btn_long` asserts `LONG_CYCLES` cycles after the `btn_press` cycle.
- `btn_press` and `btn_long` never coincide on a channel, because `LONG_CYCLES` >= 1.
- All outputs are registered; there is no combinational path from `btn_raw` or `RST` to any output.
- Consumers may act on pulses directly, with no further edge detection needed.

## Configuration
- `BUTTON_DEBOUNCE_LONGPRESS_EN` defined:
  - Hold counters and `btn_long` logic are compiled in, as described above.
- Not defined:
  - No hold counters are built and `btn_long` is tied to 0.
  - `LONG_CYCLES` is accepted but ignored.
  - All other behaviour and timing are identical.

## Test plan
All scenarios use `N`=4, `SYNC_STAGES`=2, `DB_CYCLES`=4, `LONG_CYCLES`=10, macro defined unless noted.
- Clean press: `btn_raw[0]` 0->1 held 20 cycles -> `btn_level[0]`=1 and `btn_press[0]`=1 exactly 6 cycles after the first sampling edge, for one cycle. Other channels stay 0.
- Bounce rejection:
  - Stimulus: `btn_raw[1]` toggles 1,0,1,0 on alternate cycles for 8 cycles, then held 1.
  - Required response: no pulse during the bounce; one `btn_press[1]` at 6 cycles after the final stable edge.
  - Release with 3-cycle bounce -> single `btn_release[1]`.
- Long press: `btn_raw[2]` held 30 cycles -> one `btn_long[2]` exactly 10 cycles after `btn_press[2]`. A 5-cycle hold gives no `btn_long`.
- Simultaneous channels: `btn_raw` 0000->1111 in one cycle -> `btn_press`=1111 in the same cycle. Release all -> `btn_release`=1111 together.
- Reset mid-operation:
  - `RST` high for 1 cycle, 2 cycles into a debounce, then button held -> all outputs 0 during reset, and `btn_press` 6 cycles after the first post-reset sample.
  - `RST` during a hold -> no `btn_long`.
- Macro undefined: repeat the long-press scenario -> `btn_long` stays 0000; `btn_press` and `btn_release` timing unchanged.
